// File: rtl/voice_mixer_dac.sv
// voice_mixer_dac: snapshots NUM_VOICES unsigned voices on each sample_clock
// rising edge, mixes them one voice per clk with per-voice gain, saturates the
// result back to BITDEPTH unsigned and drives a first-order delta-sigma bit.
module voice_mixer_dac #(
    parameter int BITDEPTH   = 14,
    parameter int NUM_VOICES = 4,
    parameter int GAIN_BITS  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            sample_clock,
    input  logic [NUM_VOICES*BITDEPTH-1:0]  voices_in,
    input  logic [NUM_VOICES*GAIN_BITS-1:0] voice_gain,
    input  logic [NUM_VOICES-1:0]           voice_enable,
    output logic [BITDEPTH-1:0]             mix_out,
    output logic                            mix_valid,
    output logic                            clip,
    output logic                            pdm_out
);

    localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int ACC_W  = BITDEPTH + GAIN_BITS + $clog2(NUM_VOICES) + 1;
    localparam int PROD_W = BITDEPTH + GAIN_BITS + 2;

    localparam logic [IDX_W-1:0]           LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [BITDEPTH-1:0]        MID      = {1'b1, {(BITDEPTH-1){1'b0}}};
    localparam logic signed [ACC_W-1:0]    S_MAX    = ACC_W'(2**(BITDEPTH-1) - 1);
    localparam logic signed [ACC_W-1:0]    S_MIN    = ACC_W'(-(2**(BITDEPTH-1)));

    typedef enum logic [1:0] {IDLE, ACCUM, SCALE} state_t;

    // Centre the unsigned voice on MID and scale by the unsigned gain.
    function automatic logic signed [ACC_W-1:0] voice_term(
        input logic [BITDEPTH-1:0]  voice,
        input logic [GAIN_BITS-1:0] gain
    );
        logic signed [BITDEPTH:0]   centered;
        logic signed [GAIN_BITS:0]  g;
        logic signed [PROD_W-1:0]   prod;
        centered = $signed({1'b0, voice}) - $signed({1'b0, MID});
        g        = $signed({1'b0, gain});
        prod     = PROD_W'(centered) * PROD_W'(g);
        return ACC_W'(prod);
    endfunction

    // Drop the gain fraction (floor) and clamp to the unsigned output range.
    // Result is {clip, mix}.
    function automatic logic [BITDEPTH:0] saturate(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] s;
        s = acc >>> GAIN_BITS;
        if (s > S_MAX) begin
            return {1'b1, {BITDEPTH{1'b1}}};
        end else if (s < S_MIN) begin
            return {1'b1, {BITDEPTH{1'b0}}};
        end else begin
            return {1'b0, s[BITDEPTH-1:0] + MID};
        end
    endfunction

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [BITDEPTH-1:0]       mix_q, mix_d;
    logic                      clip_q, clip_d;
    logic                      valid_q, valid_d;
    logic [BITDEPTH:0]         ds_q, ds_d;
    logic                      pdm_q, pdm_d;
    logic                      sc_dly_q;
    logic                      start;
    logic                      capture;

    logic [BITDEPTH-1:0]       voice_s_q [NUM_VOICES];
    logic [GAIN_BITS-1:0]      gain_s_q  [NUM_VOICES];
    logic [NUM_VOICES-1:0]     en_s_q;

    assign start = sample_clock & ~sc_dly_q;

    // Next-state logic: mixer FSM plus the free-running delta-sigma modulator.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        mix_d   = mix_q;
        clip_d  = clip_q;
        valid_d = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (en_s_q[idx_q]) begin
                    acc_d = acc_q + voice_term(voice_s_q[idx_q], gain_s_q[idx_q]);
                end
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = SCALE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            SCALE: begin
                {clip_d, mix_d} = saturate(acc_q);
                valid_d         = 1'b1;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ds_d  = {1'b0, ds_q[BITDEPTH-1:0]} + {1'b0, mix_q};
        pdm_d = ds_q[BITDEPTH];
    end

    // Control, accumulator, outputs and modulator state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            acc_q    <= '0;
            mix_q    <= MID;
            clip_q   <= 1'b0;
            valid_q  <= 1'b0;
            ds_q     <= '0;
            pdm_q    <= 1'b0;
            sc_dly_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            mix_q    <= mix_d;
            clip_q   <= clip_d;
            valid_q  <= valid_d;
            ds_q     <= ds_d;
            pdm_q    <= pdm_d;
            sc_dly_q <= sample_clock;
        end
    end

    // Input snapshot taken on the accepted start so later input changes cannot disturb the mix.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                voice_s_q[v] <= voices_in[v*BITDEPTH +: BITDEPTH];
                gain_s_q[v]  <= voice_gain[v*GAIN_BITS +: GAIN_BITS];
            end
            en_s_q <= voice_enable;
        end
    end

    assign mix_out   = mix_q;
    assign clip      = clip_q;
    assign mix_valid = valid_q;
    assign pdm_out   = pdm_q;

endmodule

// File: tb/tb_voice_mixer_dac.sv
// tb_voice_mixer_dac: directed stimulus, behavioural mix model compared every
// cycle, plus literal expectations for the hand-worked cases.
module tb_voice_mixer_dac;

    localparam int MID = 8192;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_clock;
    logic [55:0] voices_in;
    logic [15:0] voice_gain;
    logic [3:0]  voice_enable;
    logic [13:0] mix_out;
    logic        mix_valid;
    logic        clip;
    logic        pdm_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    voice_mixer_dac #(.BITDEPTH(14), .NUM_VOICES(4), .GAIN_BITS(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_clock (sample_clock),
        .voices_in    (voices_in),
        .voice_gain   (voice_gain),
        .voice_enable (voice_enable),
        .mix_out      (mix_out),
        .mix_valid    (mix_valid),
        .clip         (clip),
        .pdm_out      (pdm_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d..%0d", name, act, lo, hi);
        end
    endtask

    // Mix computed straight from the arithmetic rules: centred voice times gain,
    // summed, divided by 16 rounding toward -inf, clamped to 0..16383.
    task automatic model_mix(input logic [55:0] v, input logic [15:0] g, input logic [3:0] e,
                             output int mix, output int clp);
        int sum;
        int s;
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            if (e[i]) sum += (int'(v[i*14 +: 14]) - MID) * int'(g[i*4 +: 4]);
        end
        s = sum / 16;
        if ((sum % 16 != 0) && (sum < 0)) s -= 1;
        if (s > MID - 1) begin
            mix = 16383; clp = 1;
        end else if (s < -MID) begin
            mix = 0; clp = 1;
        end else begin
            mix = s + MID; clp = 0;
        end
    endtask

    // Model + compare: each falling edge applies the preceding rising edge to
    // the model (using inputs recorded before that edge), then compares.
    initial begin : model_proc
        int          pend;
        bit          sc_prev;
        bit          prev_rst;
        int          m_mix, m_clip, m_valid, nm, nc;
        logic [55:0] pv, sv;
        logic [15:0] pg, sg;
        logic [3:0]  pe, se;
        bit          psc;
        pend = 0; sc_prev = 1; prev_rst = 0;
        m_mix = MID; m_clip = 0; m_valid = 0;
        pv = '0; pg = '0; pe = '0; psc = 1; sv = '0; sg = '0; se = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 0; sc_prev = 1; m_mix = MID; m_clip = 0; m_valid = 0;
            end else if (prev_rst) begin
                m_valid = 0;
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        model_mix(sv, sg, se, nm, nc);
                        m_mix = nm; m_clip = nc; m_valid = 1;
                    end
                end else if (psc && !sc_prev) begin
                    sv = pv; sg = pg; se = pe;
                    pend = 5;
                end
                sc_prev = psc;
            end
            check("mix_valid", int'(mix_valid), m_valid);
            check("mix_out", int'(mix_out), m_mix);
            check("clip", int'(clip), m_clip);
            prev_rst = rst_n;
            pv = voices_in; pg = voice_gain; pe = voice_enable; psc = sample_clock;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_window(input int n, output int lat, output int nval);
        lat = -1; nval = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (mix_valid) begin
                nval++;
                if (lat < 0) lat = i;
            end
        end
    endtask

    // Raise sample_clock (cycle t) and watch the following 12 cycles.
    task automatic do_mix(input logic [55:0] v, input logic [15:0] g, input logic [3:0] e,
                          output int lat, output int nval);
        voices_in = v; voice_gain = g; voice_enable = e;
        sample_clock = 1'b1;
        run_window(12, lat, nval);
        sample_clock = 1'b0;
        tick();
        tick();
    endtask

    localparam logic [55:0] V_T2 = {14'd777, 14'd16000, 14'd5, 14'd12288};

    initial begin : stim
        int lat, nval, ones;
        rst_n = 1'b0; sample_clock = 1'b1;
        voices_in = '0; voice_gain = '0; voice_enable = '0;

        // Reset values, then release with sample_clock already high.
        repeat (3) tick();
        check("rst_mix_out", int'(mix_out), 8192);
        check("rst_clip", int'(clip), 0);
        check("rst_mix_valid", int'(mix_valid), 0);
        check("rst_pdm_out", int'(pdm_out), 0);
        rst_n = 1'b1;
        run_window(10, lat, nval);
        check("release_no_valid", nval, 0);
        check("release_mix_out", int'(mix_out), 8192);
        sample_clock = 1'b0;
        tick();

        // Single voice at gain 8/16.
        do_mix(V_T2, 16'hFFF8, 4'b0001, lat, nval);
        check("v0_latency", lat, 6);
        check("v0_nvalid", nval, 1);
        check("v0_mix_out", int'(mix_out), 10240);
        check("v0_clip", int'(clip), 0);
        ones = 0;
        for (int i = 0; i < 16384; i++) begin
            tick();
            ones += int'(pdm_out);
        end
        check_range("pdm_density", ones, 10239, 10241);

        // Full-scale positive and negative saturation.
        do_mix({4{14'd16383}}, 16'hFFFF, 4'b1111, lat, nval);
        check("pos_sat_mix_out", int'(mix_out), 16383);
        check("pos_sat_clip", int'(clip), 1);
        do_mix('0, 16'hFFFF, 4'b1111, lat, nval);
        check("neg_sat_mix_out", int'(mix_out), 0);
        check("neg_sat_clip", int'(clip), 1);

        // Only enabled voices contribute.
        do_mix({14'd0, 14'd9216, 14'd0, 14'd9216}, 16'hFFFF, 4'b0101, lat, nval);
        check("en0101_mix_out", int'(mix_out), 10112);
        check("en0101_clip", int'(clip), 0);

        // All voices disabled gives silence.
        do_mix({4{14'd16383}}, 16'hFFFF, 4'b0000, lat, nval);
        check("all_off_mix_out", int'(mix_out), 8192);
        check("all_off_clip", int'(clip), 0);

        // Inputs scrambled every clk after capture, plus a second edge during ACCUM.
        voices_in = {14'd0, 14'd0, 14'd8142, 14'd8292};
        voice_gain = 16'h0023; voice_enable = 4'b0011;
        sample_clock = 1'b1;
        nval = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (mix_valid) nval++;
            voices_in = 56'({$urandom(), $urandom()});
            voice_gain = 16'($urandom());
            voice_enable = 4'($urandom());
            if (i == 1) sample_clock = 1'b0;
            if (i == 2) sample_clock = 1'b1;
        end
        check("snapshot_nvalid", nval, 1);
        check("snapshot_mix_out", int'(mix_out), 8204);
        sample_clock = 1'b0;
        tick();
        tick();

        // Reset in cycle t+2 of a mix aborts it.
        voices_in = V_T2; voice_gain = 16'hFFF8; voice_enable = 4'b0001;
        sample_clock = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        nval = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mix_valid) nval++;
            check("abort_mix_out", int'(mix_out), 8192);
            check("abort_clip", int'(clip), 0);
        end
        rst_n = 1'b1;
        run_window(10, lat, nval);
        check("abort_no_valid", nval, 0);
        sample_clock = 1'b0;
        tick();
        do_mix(V_T2, 16'hFFF8, 4'b0001, lat, nval);
        check("post_abort_latency", lat, 6);
        check("post_abort_mix_out", int'(mix_out), 10240);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
